// File: rtl/serial_rx_pkg.sv
// Shared types for the serial word receiver: FSM state encoding and bit-order constants.
// The ST_PAR state only exists when SERIAL_RX_PARITY_EN is defined.
package serial_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
`ifdef SERIAL_RX_PARITY_EN
        ST_PAR   = 2'd2,
`endif
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_rx_bitcnt.sv
// Frame bit counter: clear (optionally loading 1), increment, and a flag raised
// when the next increment will complete the word.
module serial_rx_bitcnt #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic last
);

    logic [CW-1:0] count;

    // clr together with inc loads 1: the bit that restarts a frame is counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= inc ? CW'(1) : '0;
        else if (inc)
            count <= count + CW'(1);
    end

    assign last = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver with frame sync, ready/valid output and sticky overrun.
// Optional even-parity bit after each word: define SERIAL_RX_PARITY_EN.
module serial_word_receiver
    import serial_rx_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin_valid,
    input  logic             sin_data,
    input  logic             sin_first,
    input  logic             dir,
    input  logic             par_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] par_data,
    output logic             par_valid,
    output logic             busy,
    output logic             overrun,
    output logic             sync_err
`ifdef SERIAL_RX_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    state_t state, state_nxt;
    logic   load, shift, sync, drop, accept, last, dir_q, shift_dir;
`ifdef SERIAL_RX_PARITY_EN
    logic   take_par;
`endif

    serial_rx_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (load),
        .inc  (load | shift),
        .last (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        sync      = 1'b0;
        drop      = 1'b0;
        accept    = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        take_par  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (sin_valid && sin_first) begin
                    load      = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sin_valid && sin_first) begin
                    load = 1'b1;
                    sync = 1'b1;
                end else if (sin_valid) begin
                    shift = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                    if (last) state_nxt = ST_PAR;
`else
                    if (last) state_nxt = ST_HOLD;
`endif
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            ST_PAR: begin
                if (sin_valid && sin_first) begin
                    load      = 1'b1;
                    sync      = 1'b1;
                    state_nxt = ST_SHIFT;
                end else if (sin_valid) begin
                    take_par  = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
`endif
            ST_HOLD: begin
                // Handshake frees the word; a frame start on the same edge is taken, not dropped.
                if (par_ready) begin
                    accept = 1'b1;
                    if (sin_valid && sin_first) begin
                        load      = 1'b1;
                        state_nxt = ST_SHIFT;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (sin_valid) begin
                    drop = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The first bit of a frame uses the live dir; the rest use the latched copy.
    assign shift_dir = load ? dir : dir_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_data <= '0;
            dir_q    <= DIR_LSB_FIRST;
            sync_err <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (load || shift)
                par_data <= (shift_dir == DIR_MSB_FIRST) ? {par_data[WIDTH-2:0], sin_data}
                                                         : {sin_data, par_data[WIDTH-1:1]};
            if (load) dir_q <= dir;
            sync_err <= sync;
            if (drop)         overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           parity_err <= 1'b0;
        else if (take_par) parity_err <= (^par_data) ^ sin_data;
        else if (accept)   parity_err <= 1'b0;
    end
    assign busy = (state == ST_SHIFT) || (state == ST_PAR);
`else
    assign busy = (state == ST_SHIFT);
`endif

    assign par_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: directed scenarios then random traffic, all
// checked against a bit-queue reference model.
module tb_serial_word_receiver;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             sin_valid = 1'b0, sin_data = 1'b0, sin_first = 1'b0;
    logic             dir = 1'b0, par_ready = 1'b0, ovr_clr = 1'b0;
    logic [WIDTH-1:0] par_data;
    logic             par_valid, busy, overrun, sync_err;
`ifdef SERIAL_RX_PARITY_EN
    logic             parity_err;
`endif

    serial_word_receiver #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin_data(sin_data),
        .sin_first(sin_first), .dir(dir), .par_ready(par_ready), .ovr_clr(ovr_clr),
        .par_data(par_data), .par_valid(par_valid), .busy(busy),
        .overrun(overrun), .sync_err(sync_err)
`ifdef SERIAL_RX_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a frame is a queue of received bits, assembled into a word by index.
    bit               m_in_frame, m_par_phase, m_valid, m_ovr, m_sync, m_perr, m_dir;
    bit               q[$];
    logic [WIDTH-1:0] m_word;

    task automatic model_reset();
        m_in_frame = 0; m_par_phase = 0; m_valid = 0; m_ovr = 0;
        m_sync = 0; m_perr = 0; m_dir = 0; m_word = '0;
        q.delete();
    endtask

    task automatic start_frame(input logic d, input logic dr);
        q.delete();
        q.push_back(d);
        m_dir = dr; m_in_frame = 1; m_par_phase = 0;
    endtask

    task automatic model_step(input logic v, d, f, dr, rdy, clr);
        bit set_ovr;
        set_ovr = 0;
        m_sync  = 0;
        if (m_valid) begin
            if (rdy) begin
                m_valid = 0; m_perr = 0;
                if (v && f) start_frame(d, dr);
            end else if (v) set_ovr = 1;
        end else if (v && f) begin
            m_sync = m_in_frame;
            start_frame(d, dr);
        end else if (v && m_in_frame) begin
            if (m_par_phase) begin
                m_perr = (^m_word) ^ d;
                m_valid = 1; m_in_frame = 0; m_par_phase = 0;
            end else begin
                q.push_back(d);
                if (q.size() == WIDTH) begin
                    for (int i = 0; i < WIDTH; i++)
                        m_word[m_dir ? WIDTH-1-i : i] = q[i];
`ifdef SERIAL_RX_PARITY_EN
                    m_par_phase = 1;
`else
                    m_valid = 1; m_in_frame = 0;
`endif
                end
            end
        end
        if (set_ovr)  m_ovr = 1;
        else if (clr) m_ovr = 0;
    endtask

    task automatic check_outputs();
        chk("par_valid", par_valid, m_valid);
        chk("busy", busy, m_in_frame);
        chk("overrun", overrun, m_ovr);
        chk("sync_err", sync_err, m_sync);
        if (m_valid) chk("par_data", par_data, m_word);
`ifdef SERIAL_RX_PARITY_EN
        if (m_valid) chk("parity_err", parity_err, m_perr);
`endif
    endtask

    task automatic cyc(input logic v, d, f, dr, rdy, clr);
        sin_valid = v; sin_data = d; sin_first = f; dir = dr; par_ready = rdy; ovr_clr = clr;
        @(posedge clk);
        model_step(v, d, f, dr, rdy, clr);
        #1 check_outputs();
    endtask

    // seq[0] goes on the wire first; a correct even-parity bit follows when enabled.
    task automatic send_frame(input logic dr, input logic [WIDTH-1:0] seq);
        for (int i = 0; i < WIDTH; i++) cyc(1'b1, seq[i], i == 0, dr, 1'b0, 1'b0);
`ifdef SERIAL_RX_PARITY_EN
        cyc(1'b1, ^seq, 1'b0, dr, 1'b0, 1'b0);
`endif
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk({tag, "_data"}, par_data, 0);
        chk({tag, "_valid"}, par_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ovr"}, overrun, 0);
        chk({tag, "_sync"}, sync_err, 0);
`ifdef SERIAL_RX_PARITY_EN
        chk({tag, "_perr"}, parity_err, 0);
`endif
        sin_valid = 1'b0; sin_first = 1'b0; par_ready = 1'b0; ovr_clr = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        model_reset();
        async_reset("rst0");

        // LSB first: 1,0,1,1 -> 1101, valid right after the last bit
        cyc(1, 1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0, 0);
        chk("lsb_not_yet", par_valid, 0);
        cyc(1, 1, 0, 0, 0, 0);
`ifdef SERIAL_RX_PARITY_EN
        cyc(1, 1, 0, 0, 0, 0);
`endif
        chk("lsb_valid", par_valid, 1);
        chk("lsb_data", par_data, 4'b1101);
        cyc(0, 0, 0, 0, 1, 0);

        // MSB first, then stalled downstream with two dropped bits
        send_frame(1'b1, 4'b1101);
        chk("msb_data", par_data, 4'b1011);
        for (int i = 0; i < 5; i++) cyc(i == 1 || i == 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_set", overrun, 1);
        chk("ovr_data", par_data, 4'b1011);
        cyc(0, 0, 0, 0, 1, 1);
        chk("ovr_clr", overrun, 0);

        // Restart mid-word
        cyc(1, 1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        chk("sync_pulse", sync_err, 1);
        cyc(1, 0, 0, 0, 0, 0);
        chk("sync_one_cycle", sync_err, 0);
        cyc(1, 1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0, 0);
`ifdef SERIAL_RX_PARITY_EN
        cyc(1, 0, 0, 0, 0, 0);
`endif
        chk("sync_data", par_data, 4'b1100);

        // Accept and start next frame on the same edge; 3 more bits complete it
        cyc(1, 1, 1, 0, 1, 0);
        chk("b2b_busy", busy, 1);
        chk("b2b_ovr", overrun, 0);
        cyc(1, 1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0);
`ifdef SERIAL_RX_PARITY_EN
        cyc(1, 1, 0, 0, 0, 0);
`endif
        chk("b2b_valid", par_valid, 1);
        chk("b2b_data", par_data, 4'b0111);
        cyc(0, 0, 0, 0, 1, 0);

        // Reset in the middle of a frame; following bits lack sin_first
        cyc(1, 1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0);
        sin_valid = 1'b1; sin_data = 1'b1;
        async_reset("rst_mid");
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0);
        chk("rst_ignore", busy, 0);

`ifdef SERIAL_RX_PARITY_EN
        for (int p = 0; p < 2; p++) begin
            cyc(1, 1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0);
            cyc(1, p[0], 0, 0, 0, 0);
            chk("par_word", par_data, 4'b0111);
            chk("par_err", parity_err, p == 0);
            cyc(0, 0, 0, 0, 1, 0);
        end
`endif

        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom_range(0, 9) < 1,
                $urandom_range(0, 1), $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_word_receiver.md
SERIAL_WORD_RECEIVER -- requirements
Module: serial_word_receiver

Interface
REQ-001 SHALL have parameter WIDTH, default 4, parallel word width (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port sin_valid, input, 1, serial bit qualifier.
REQ-005 SHALL have port sin_data, input, 1, serial data bit.
REQ-006 SHALL have port sin_first, input, 1, marks first bit of a frame (valid only with sin_valid).
REQ-007 SHALL have port dir, input, 1, frame bit order: 0 = LSB first, 1 = MSB first.
REQ-008 SHALL have port par_ready, input, 1, downstream accepts word.
REQ-009 SHALL have port ovr_clr, input, 1, clears sticky overrun flag.
REQ-010 SHALL have port par_data, output, WIDTH, assembled word.
REQ-011 SHALL have port par_valid, output, 1, par_data holds a complete word.
REQ-012 SHALL have port busy, output, 1, frame in progress (state SHIFT or PAR).
REQ-013 SHALL have port overrun, output, 1, sticky flag: bit dropped while word unaccepted.
REQ-014 SHALL have port sync_err, output, 1, one-cycle pulse when a frame restarts mid-word.

Function
REQ-015 SHALL implement states IDLE, SHIFT, PAR (PARITY_EN builds only) and HOLD.
REQ-016 IDLE: sin_valid with sin_first SHALL latch dir, shift in the bit, set count to 1, go SHIFT; sin_valid without sin_first SHALL be ignored.
REQ-017 With dir=0, each accepted bit SHALL enter at bit WIDTH-1 while the shift register moves right; with dir=1, each bit SHALL enter at bit 0 while the register moves left.
REQ-018 SHIFT: each sin_valid SHALL shift one bit and increment count; the bit making count equal WIDTH SHALL move to PAR (if enabled) or HOLD.
REQ-019 par_valid SHALL assert on the clock edge that samples the last data bit (registered, visible the next cycle) and hold until par_ready is high on an edge.
REQ-020 par_data SHALL stay stable while par_valid is high.
REQ-021 HOLD with par_valid and par_ready: the SHALL go to IDLE; a simultaneous sin_valid with sin_first SHALL start the next frame (go SHIFT, count 1) in the same edge.
REQ-022 HOLD without handshake: any sin_valid SHALL be dropped and overrun set; par_data SHALL be unchanged.
REQ-023 sin_first with sin_valid in SHIFT or PAR SHALL discard the partial word, restart at count 1 with that bit, and pulse sync_err.
REQ-024 overrun SHALL clear on ovr_clr; a simultaneous set condition SHALL win.
REQ-025 sin_valid low SHALL stall the frame indefinitely with no timeout.

Reset
REQ-026 rst SHALL force state IDLE, count 0, par_data 0, par_valid 0, busy 0, overrun 0, sync_err 0, parity_err 0, independently of clk.
REQ-027 rst deasserted mid-frame SHALL resume only at the next sin_first.

Configuration
REQ-028 With SERIAL_RX_PARITY_EN defined, one even-parity bit SHALL follow the data bits: state PAR consumes it, then goes to HOLD with par_valid asserted, and output parity_err (1 bit) SHALL be set when the XOR of data and parity bits is 1 and held with par_valid.
REQ-029 Without SERIAL_RX_PARITY_EN, there SHALL be no PAR state and no parity_err port, and HOLD SHALL follow the last data bit.

Structure
REQ-030 Package serial_rx_pkg SHALL hold the state enum type and the DIR_LSB_FIRST/DIR_MSB_FIRST constants.
REQ-031 Sub-module serial_rx_bitcnt SHALL implement the clear/increment/terminal-count bit counter of width $clog2(WIDTH+1).

Verification
REQ-032 WIDTH=4, dir=0, bits 1,0,1,1 with first on bit 1 -> par_data=4'b1101, par_valid one cycle after the 4th bit.
REQ-033 WIDTH=4, dir=1, bits 1,0,1,1 -> par_data=4'b1011; par_ready held low 5 cycles with 2 extra sin_valid -> overrun=1, par_data unchanged.
REQ-034 Two bits, then sin_first with bit 0, then 0,1,1 (dir=0) -> sync_err pulse, par_data=4'b1100.
REQ-035 Handshake and a new sin_first on the same edge -> word accepted, busy=1, count=1, no overrun.
REQ-036 Assert rst at bit 3 -> all outputs 0 asynchronously; bits without sin_first afterwards are ignored.
REQ-037 SERIAL_RX_PARITY_EN, data 4'b0111 with parity 0 -> parity_err=1; with parity 1 -> parity_err=0.
